// File: rtl/icape_pkg.sv
// Shared constants and state types for the ICAPE2 reboot controller.
package icape_pkg;

    // ICAPE2 configuration register addresses
    localparam logic [4:0]  RegWbstar  = 5'h10;
    localparam logic [4:0]  RegCmd     = 5'h04;
    localparam logic [4:0]  RegBootsts = 5'h16;

    // CMD register opcode that triggers reconfiguration
    localparam logic [31:0] IprogWord  = 32'h0000_000F;

    typedef enum logic [3:0] {
        StIdle,
        StWstarReq,
        StWstarAck,
        StGap,
        StCmdReq,
        StCmdAck,
        StRdReq,
        StRdAck,
        StDone
    } ctrl_state_e;

    typedef enum logic [1:0] {
        PhIdle,
        PhReq,
        PhAck
    } xact_phase_e;

endpackage

// File: rtl/wb_single_xact.sv
// Single-transaction Wishbone master: launches one strobe on go_i, waits for
// ack, and aborts if the slave does not answer within the timeout window.
module wb_single_xact
    import icape_pkg::*;
#(
    parameter int unsigned LGTIMEOUT = 12
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        go_i,
    input  logic        we_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] data_i,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_data_i,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [4:0]  addr_o,
    output logic [31:0] data_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        timeout_o
);

    xact_phase_e          phase_q, phase_d;
    logic                 we_q, we_d;
    logic [4:0]           addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    logic [LGTIMEOUT-1:0] cnt_q, cnt_d;
    logic [LGTIMEOUT-1:0] cnt_inc;

    assign cnt_inc   = cnt_q + 1'b1;
    assign cyc_o     = (phase_q != PhIdle);
    assign stb_o     = (phase_q == PhReq);
    assign we_o      = we_q;
    assign addr_o    = addr_q;
    assign data_o    = data_q;
    assign rdata_o   = wb_data_i;
    // Acks seen while cyc is low are stray and ignored
    assign done_o    = cyc_o && wb_ack_i;
    // Abort on the edge where the count would reach all-ones; ack wins a tie
    assign timeout_o = cyc_o && !wb_ack_i && (&cnt_inc);

    // Next-state: launch, stall/ack tracking, timeout counting
    always_comb begin
        phase_d = phase_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (phase_q)
            PhIdle: begin
                if (go_i) begin
                    phase_d = PhReq;
                    we_d    = we_i;
                    addr_d  = addr_i;
                    data_d  = data_i;
                    cnt_d   = '0;
                end
            end
            PhReq: begin
                cnt_d = cnt_inc;
                if (!wb_stall_i) begin
                    phase_d = PhAck;
                end
            end
            PhAck: begin
                cnt_d = cnt_inc;
            end
            default: phase_d = PhIdle;
        endcase
        if (done_o || timeout_o) begin
            phase_d = PhIdle;
            we_d    = 1'b0;
            addr_d  = '0;
            data_d  = '0;
            cnt_d   = '0;
        end
    end

    // Transaction state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= PhIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/icape_reboot_ctrl.sv
// ICAPE2 reboot controller: sequences WBSTAR + IPROG writes for a warm boot,
// or a single BOOTSTS read, through one Wishbone transaction engine.
module icape_reboot_ctrl
    import icape_pkg::*;
#(
    parameter int unsigned LGTIMEOUT = 12
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_boot_req,
    input  logic [31:0] i_boot_addr,
    input  logic        i_status_req,
    output logic        o_busy,
    output logic [31:0] o_status,
    output logic        o_status_valid,
    output logic        o_err,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [4:0]  o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data
);

    ctrl_state_e state_q, state_d;
    logic [31:0] boot_addr_q, boot_addr_d;
    logic [31:0] status_q, status_d;
    logic        status_valid_q, status_valid_d;
    logic        err_q, err_d;

    logic        x_go, x_we, x_done, x_timeout;
    logic [4:0]  x_addr;
    logic [31:0] x_wdata, x_rdata;

    wb_single_xact #(
        .LGTIMEOUT(LGTIMEOUT)
    ) u_xact (
        .clk_i     (i_clk),
        .rst_ni    (i_reset_n),
        .go_i      (x_go),
        .we_i      (x_we),
        .addr_i    (x_addr),
        .data_i    (x_wdata),
        .wb_stall_i(i_wb_stall),
        .wb_ack_i  (i_wb_ack),
        .wb_data_i (i_wb_data),
        .cyc_o     (o_wb_cyc),
        .stb_o     (o_wb_stb),
        .we_o      (o_wb_we),
        .addr_o    (o_wb_addr),
        .data_o    (o_wb_data),
        .done_o    (x_done),
        .rdata_o   (x_rdata),
        .timeout_o (x_timeout)
    );

    assign o_busy         = (state_q != StIdle) && (state_q != StDone);
    assign o_status       = status_q;
    assign o_status_valid = status_valid_q;
    assign o_err          = err_q;

    // Sequencer: request acceptance, per-step transaction launch and completion
    always_comb begin
        state_d        = state_q;
        boot_addr_d    = boot_addr_q;
        status_d       = status_q;
        status_valid_d = 1'b0;
        err_d          = 1'b0;
        x_go           = 1'b0;
        x_we           = 1'b0;
        x_addr         = '0;
        x_wdata        = '0;
        unique case (state_q)
            StIdle: begin
                // Boot takes priority over a simultaneous status request
                if (i_boot_req) begin
                    state_d     = StWstarReq;
                    boot_addr_d = i_boot_addr;
                end else if (i_status_req) begin
                    state_d = StRdReq;
                end
            end
            StWstarReq, StWstarAck: begin
                // The engine only samples go while it is idle
                x_go    = (state_q == StWstarReq);
                x_we    = 1'b1;
                x_addr  = RegWbstar;
                x_wdata = boot_addr_q;
                if (x_timeout) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (x_done) begin
                    state_d = StGap;
                end else if (state_q == StWstarReq && o_wb_stb && !i_wb_stall) begin
                    state_d = StWstarAck;
                end
            end
            StGap: begin
                // Launching here gives exactly one cyc-low cycle between writes
                x_go    = 1'b1;
                x_we    = 1'b1;
                x_addr  = RegCmd;
                x_wdata = IprogWord;
                state_d = StCmdReq;
            end
            StCmdReq, StCmdAck: begin
                x_we    = 1'b1;
                x_addr  = RegCmd;
                x_wdata = IprogWord;
                if (x_timeout) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (x_done) begin
                    state_d = StDone;
                end else if (state_q == StCmdReq && o_wb_stb && !i_wb_stall) begin
                    state_d = StCmdAck;
                end
            end
            StRdReq, StRdAck: begin
                x_go   = (state_q == StRdReq);
                x_addr = RegBootsts;
                if (x_timeout) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (x_done) begin
                    state_d        = StDone;
                    status_d       = x_rdata;
                    status_valid_d = 1'b1;
                end else if (state_q == StRdReq && o_wb_stb && !i_wb_stall) begin
                    state_d = StRdAck;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state and result registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= StIdle;
            boot_addr_q    <= '0;
            status_q       <= '0;
            status_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            boot_addr_q    <= boot_addr_d;
            status_q       <= status_d;
            status_valid_q <= status_valid_d;
            err_q          <= err_d;
        end
    end

endmodule

// File: tb/tb_icape_reboot_ctrl.sv
// Self-checking bench for icape_reboot_ctrl: table of request vectors against a
// configurable slave model, plus hand sequences for timeout and mid-cycle reset.
`timescale 1ns/1ps
module tb_icape_reboot_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, boot_req, status_req, busy, status_valid, err;
    logic [31:0] boot_addr, status;
    logic        cyc, stb, we, ack, stall;
    logic [4:0]  addr;
    logic [31:0] wdata, rdata;

    logic        boot_req4, status_req4, busy4, sv4, err4;
    logic [31:0] boot_addr4, status4;
    logic        cyc4, stb4, we4;
    logic [4:0]  addr4;
    logic [31:0] wdata4;
    logic        ack4 = 1'b0;
    logic        stall4 = 1'b0;
    logic [31:0] rdata4 = 32'h0;

    icape_reboot_ctrl u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_boot_req(boot_req), .i_boot_addr(boot_addr),
        .i_status_req(status_req), .o_busy(busy), .o_status(status),
        .o_status_valid(status_valid), .o_err(err), .o_wb_cyc(cyc), .o_wb_stb(stb),
        .o_wb_we(we), .o_wb_addr(addr), .o_wb_data(wdata), .i_wb_ack(ack),
        .i_wb_stall(stall), .i_wb_data(rdata)
    );

    icape_reboot_ctrl #(.LGTIMEOUT(4)) u_dut4 (
        .i_clk(clk), .i_reset_n(rst_n), .i_boot_req(boot_req4), .i_boot_addr(boot_addr4),
        .i_status_req(status_req4), .o_busy(busy4), .o_status(status4),
        .o_status_valid(sv4), .o_err(err4), .o_wb_cyc(cyc4), .o_wb_stb(stb4),
        .o_wb_we(we4), .o_wb_addr(addr4), .o_wb_data(wdata4), .i_wb_ack(ack4),
        .i_wb_stall(stall4), .i_wb_data(rdata4)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } xact_t;

    xact_t       exp_q[$];
    logic [31:0] stat_q[$];
    int          sv_cnt  = 0;
    int          err_cnt = 0;
    logic [31:0] last_status = 32'h0;

    // Slave configuration
    int          cfg_stall = 0;
    int          cfg_ackd  = 0;
    logic [31:0] cfg_rdata = 32'h0;

    // Slave model: stalls cfg_stall cycles, acks cfg_ackd cycles after acceptance
    initial begin
        int stall_left, ack_left;
        bit pend;
        stall_left = 0; ack_left = 0; pend = 0;
        ack = 1'b0; stall = 1'b0; rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            ack = 1'b0; stall = 1'b0; rdata = 32'h0;
            if (!cyc) begin
                stall_left = cfg_stall;
                pend = 0;
            end else if (stb) begin
                if (stall_left > 0) begin
                    stall = 1'b1;
                    stall_left--;
                end else if (cfg_ackd == 0) begin
                    ack = 1'b1;
                    rdata = cfg_rdata;
                end else begin
                    pend = 1;
                    ack_left = cfg_ackd;
                end
            end else if (pend) begin
                ack_left--;
                if (ack_left == 0) begin
                    ack = 1'b1;
                    rdata = cfg_rdata;
                    pend = 0;
                end
            end
        end
    end

    // Bus monitor and scoreboard for the main instance
    initial begin
        xact_t e;
        forever begin
            @(negedge clk);
            if (rst_n && cyc && stb && !stall) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_xact: got addr %h data %h expected none",
                             addr, wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("xact_we", 32'(we), 32'(e.we));
                    check("xact_addr", 32'(addr), 32'(e.addr));
                    check("xact_data", wdata, e.data);
                end
            end
            if (status_valid) begin
                sv_cnt++;
                if (stat_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_status: got %h expected no pulse", status);
                end else begin
                    check("status_word", status, stat_q.pop_front());
                end
            end
            if (err) err_cnt++;
        end
    end

    typedef struct {
        bit          boot;
        bit          stat;
        bit          extra;
        logic [31:0] baddr;
        logic [31:0] rdata;
        int          stall;
        int          ackd;
    } vec_t;

    function automatic vec_t mk(bit b, bit s, bit x, logic [31:0] a, logic [31:0] r,
                                int st, int ad);
        vec_t v;
        v.boot = b; v.stat = s; v.extra = x; v.baddr = a; v.rdata = r;
        v.stall = st; v.ackd = ad;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int n, nlow, sv0, er0, bus1, exp_busy;
        cfg_stall = v.stall; cfg_ackd = v.ackd; cfg_rdata = v.rdata;
        bus1 = v.stall + v.ackd + 1;
        if (v.boot) begin
            exp_q.push_back('{we: 1'b1, addr: 5'h10, data: v.baddr});
            exp_q.push_back('{we: 1'b1, addr: 5'h04, data: 32'h0000_000F});
            exp_busy = 2 * bus1 + 2;  // setup + WBSTAR + gap + CMD
        end else begin
            exp_q.push_back('{we: 1'b0, addr: 5'h16, data: 32'h0});
            stat_q.push_back(v.rdata);
            exp_busy = bus1 + 1;      // setup + read
            last_status = v.rdata;
        end
        sv0 = sv_cnt; er0 = err_cnt;
        @(negedge clk);
        boot_req = v.boot; status_req = v.stat; boot_addr = v.baddr;
        @(negedge clk);
        boot_req = 1'b0; status_req = 1'b0; boot_addr = 32'hFFFF_0000;
        n = 0; nlow = 0;
        while (busy && n < 2000) begin
            n++;
            if (!cyc) nlow++;
            boot_req = v.extra && (n == 3);
            @(negedge clk);
        end
        boot_req = 1'b0;
        repeat (2) @(negedge clk);
        check($sformatf("v%0d_busy_cycles", idx), n, exp_busy);
        check($sformatf("v%0d_cyc_low_busy", idx), nlow, v.boot ? 2 : 1);
        check($sformatf("v%0d_xacts_left", idx), exp_q.size(), 0);
        check($sformatf("v%0d_status_pulses", idx), sv_cnt - sv0, v.boot ? 0 : 1);
        check($sformatf("v%0d_err_pulses", idx), err_cnt - er0, 0);
        check($sformatf("v%0d_status_out", idx), status, last_status);
    endtask

    vec_t vecs[6];

    initial begin
        int n, w, cmd4, er0;
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, w, cmd4, er0;
        vecs[0] = mk(1, 0, 0, 32'h0040_0000, 32'h0,         5, 40);
        vecs[1] = mk(0, 1, 0, 32'h0,         32'h0000_0001, 0, 2);
        vecs[2] = mk(1, 1, 1, 32'h1234_5678, 32'h0,         1, 3);
        vecs[3] = mk(1, 0, 0, 32'hABCD_0000, 32'h0,         0, 0);
        vecs[4] = mk(0, 1, 0, 32'h0,         32'hDEAD_BEEF, 2, 0);
        vecs[5] = mk(0, 1, 0, 32'h0,         32'h0000_A5A5, 0, 0);

        rst_n = 1'b0; boot_req = 1'b0; status_req = 1'b0; boot_addr = 32'h0;
        boot_req4 = 1'b0; status_req4 = 1'b0; boot_addr4 = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_cyc", 32'(cyc), 0);
        check("rst_stb", 32'(stb), 0);
        check("rst_we", 32'(we), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_data", wdata, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_status", status, 0);
        check("rst_status_valid", 32'(status_valid), 0);
        check("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Timeout on WBSTAR write with LGTIMEOUT=4; slave never responds
        @(negedge clk);
        boot_req4 = 1'b1; boot_addr4 = 32'h0040_0000;
        @(negedge clk);
        boot_req4 = 1'b0;
        w = 0;
        while (!cyc4 && w < 10) begin w++; @(negedge clk); end
        check("to_first_addr", 32'(addr4), 32'h10);
        check("to_first_data", wdata4, 32'h0040_0000);
        n = 0; cmd4 = 0;
        while (cyc4 && n < 100) begin
            n++;
            if (addr4 == 5'h04) cmd4++;
            @(negedge clk);
        end
        check("to_cyc_cycles", n, 15);
        check("to_err_pulse", 32'(err4), 1);
        check("to_busy_low", 32'(busy4), 0);
        @(negedge clk);
        check("to_err_single", 32'(err4), 0);
        repeat (20) begin
            if (cyc4) cmd4++;
            @(negedge clk);
        end
        check("to_no_cmd", cmd4, 0);
        check("to_status_kept", status4, 32'h0);

        // Reset asserted during CMD_ACK
        cfg_stall = 0; cfg_ackd = 30;
        exp_q.push_back('{we: 1'b1, addr: 5'h10, data: 32'h00C0_0000});
        exp_q.push_back('{we: 1'b1, addr: 5'h04, data: 32'h0000_000F});
        er0 = err_cnt + sv_cnt;
        @(negedge clk);
        boot_req = 1'b1; boot_addr = 32'h00C0_0000;
        @(negedge clk);
        boot_req = 1'b0;
        w = 0;
        while (!(cyc && !stb && addr == 5'h04) && w < 500) begin w++; @(negedge clk); end
        check("rst_reached_cmd_ack", 32'(w < 500), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cyc", 32'(cyc), 0);
        check("mid_rst_stb", 32'(stb), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_status", status, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_status = 32'h0;
        repeat (3) @(negedge clk);
        check("mid_rst_no_pulses", err_cnt + sv_cnt - er0, 0);
        check("mid_rst_xacts_left", exp_q.size(), 0);
        run_vec(6, mk(1, 0, 0, 32'h0080_0000, 32'h0, 1, 2));
        run_vec(7, mk(0, 1, 0, 32'h0, 32'h0000_0003, 0, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
